// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART controller: register map,
// STATUS/CTRL bit positions, and the TX/RX state encodings.
package uart_mmio_pkg;

  // Register select values taken from addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_TX_EMPTY  = 3;
  localparam int ST_TX_ACTIVE = 4;
  localparam int ST_RX_OVR    = 5;
  localparam int ST_TX_OVF    = 6;

  // CTRL bit positions
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_W     = 2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LOAD      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_CLR  = 1'b1
  } rx_state_t;

  // Packs the individual status flags into the 32-bit STATUS read value.
  function automatic logic [31:0] status_word(
    input logic rx_nempty,
    input logic rx_full,
    input logic tx_full,
    input logic tx_empty,
    input logic tx_active,
    input logic rx_ovr,
    input logic tx_ovf
  );
    logic [31:0] v;
    v               = '0;
    v[ST_RX_NEMPTY] = rx_nempty;
    v[ST_RX_FULL]   = rx_full;
    v[ST_TX_FULL]   = tx_full;
    v[ST_TX_EMPTY]  = tx_empty;
    v[ST_TX_ACTIVE] = tx_active;
    v[ST_RX_OVR]    = rx_ovr;
    v[ST_TX_OVF]    = tx_ovf;
    return v;
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU-side bus of the UART controller: select/write strobe, address, data
// in both directions and the level interrupt back to the CPU.
interface uart_mmio_ctrl_if;
  logic        cs;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output cs, output we, output addr, output wdata,
                  input  rdata, input irq);
  modport slave  (input  cs, input we, input addr, input wdata,
                  output rdata, output irq);
endinterface

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with one extra pointer bit for full/empty detection.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: bus decode, register file, TX and RX
// sequencing FSMs around two FIFOs, and a registered level interrupt.
//
//   state         | meaning
//   TX_IDLE       | waiting for a queued byte while the uart is not busy
//   TX_LOAD       | pop byte, present it on uart_din, pulse uart_enable
//   TX_WAIT_BUSY  | waiting for the uart to acknowledge via tx_busy=1
//   TX_WAIT_DONE  | frame in flight, waiting for tx_busy=0
//   RX_IDLE       | waiting for uart_rdy; captures the byte on its rise
//   RX_CLR        | rdy_clr pulsed, waiting for uart_rdy to drop
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clock_50MHZ,
  input  logic              reset_n,
  uart_mmio_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] uart_din,
  output logic              uart_enable,
  input  logic              uart_tx_busy,
  input  logic              uart_rdy,
  input  logic [DATA_W-1:0] uart_dout,
  output logic              uart_rdy_clr
);

  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_sel;
  logic              w_unused;

  logic              w_tx_push;
  logic              w_tx_pop;
  logic [DATA_W-1:0] w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic [DATA_W-1:0] w_rx_head;
  logic              w_rx_full;
  logic              w_rx_empty;

  logic              w_tx_ovf_set;
  logic              w_rx_ovr_set;
  logic              w_sts_wr;
  logic              w_ctrl_wr;
  logic              w_tx_start;
  logic [31:0]       w_status;

  tx_state_t         r_tx_state;
  tx_state_t         w_tx_next;
  rx_state_t         r_rx_state;
  rx_state_t         w_rx_next;

  logic [DATA_W-1:0] r_uart_din;
  logic              r_uart_enable;
  logic              r_rdy_clr;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_rx_ovr;
  logic              r_tx_ovf;
  logic [31:0]       r_rdata;
  logic              r_irq;

  assign w_wr     = bus.cs & bus.we;
  assign w_rd     = bus.cs & ~bus.we;
  assign w_sel    = bus.addr[3:2];
  // Byte-lane bits and upper data bits are don't-care for this block
  assign w_unused = ^{bus.addr[1:0], bus.wdata[31:DATA_W]};

  assign w_tx_push    = w_wr & (w_sel == REG_DATA);
  assign w_rx_pop     = w_rd & (w_sel == REG_DATA) & ~w_rx_empty;
  assign w_sts_wr     = w_wr & (w_sel == REG_STATUS);
  assign w_ctrl_wr    = w_wr & (w_sel == REG_CTRL);
  // A drop only happens when no pop frees the slot in the same cycle
  assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;
  assign w_rx_ovr_set = w_rx_push & w_rx_full & ~w_rx_pop;
  assign w_tx_start   = (r_tx_state == TX_IDLE) && (w_tx_next == TX_LOAD);

  assign w_status = status_word(~w_rx_empty, w_rx_full, w_tx_full, w_tx_empty,
                                (r_tx_state != TX_IDLE) | ~w_tx_empty,
                                r_rx_ovr, r_tx_ovf);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (clock_50MHZ),
    .i_rst_n (reset_n),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (bus.wdata[DATA_W-1:0]),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (clock_50MHZ),
    .i_rst_n (reset_n),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (uart_dout),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // TX next-state: never launch while the uart still reports busy, which
  // also protects a frame that was in flight across a reset
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE:      if (!w_tx_empty && !uart_tx_busy) w_tx_next = TX_LOAD;
      TX_LOAD: begin
        w_tx_pop  = 1'b1;
        w_tx_next = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (uart_tx_busy)  w_tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_tx_busy) w_tx_next = TX_IDLE;
      default:      w_tx_next = TX_IDLE;
    endcase
  end

  // TX state and uart drive; din is latched on entry to TX_LOAD and then
  // held until the next byte is launched
  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state    <= TX_IDLE;
      r_uart_din    <= '0;
      r_uart_enable <= 1'b0;
    end else begin
      r_tx_state    <= w_tx_next;
      r_uart_enable <= w_tx_start;
      if (w_tx_start) r_uart_din <= w_tx_head;
    end
  end

  // RX next-state: one capture per rdy assertion
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (uart_rdy) begin
        w_rx_push = 1'b1;
        w_rx_next = RX_CLR;
      end
      RX_CLR:  if (!uart_rdy) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // RX state and the rdy_clr pulse that follows each capture
  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= RX_IDLE;
      r_rdy_clr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rdy_clr  <= w_rx_push;
    end
  end

  // CTRL register and sticky error flags; a same-cycle set beats a W1C clear
  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl   <= '0;
      r_rx_ovr <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ctrl <= bus.wdata[CTRL_W-1:0];
      if (w_rx_ovr_set)
        r_rx_ovr <= 1'b1;
      else if (w_sts_wr && bus.wdata[ST_RX_OVR])
        r_rx_ovr <= 1'b0;
      if (w_tx_ovf_set)
        r_tx_ovf <= 1'b1;
      else if (w_sts_wr && bus.wdata[ST_TX_OVF])
        r_tx_ovf <= 1'b0;
    end
  end

  // Registered read mux; holds the previous value when no read is issued
  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      case (w_sel)
        REG_DATA:   r_rdata <= w_rx_empty ? '0 : {{(32-DATA_W){1'b0}}, w_rx_head};
        REG_STATUS: r_rdata <= w_status;
        REG_CTRL:   r_rdata <= {{(32-CTRL_W){1'b0}}, r_ctrl};
        default:    r_rdata <= '0;
      endcase
    end
  end

  // Level interrupt: RX data waiting, or TX fully drained and idle
  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_ctrl[CTRL_RX_IE] & ~w_rx_empty) |
               (r_ctrl[CTRL_TX_IE] & w_tx_empty & (r_tx_state == TX_IDLE));
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.irq      = r_irq;
  assign uart_din     = r_uart_din;
  assign uart_enable  = r_uart_enable;
  assign uart_rdy_clr = r_rdy_clr;

endmodule
